demux_1x8: RTL and testbench

DEMUX_1X8 -- requirements
Module: demux_1x8

---
 rtl/demux_1x8.sv | 67 ++++++
 tb/tb_demux_1x8.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer: D is steered to Y[S] one clock after sampling,
// every other output is forced to zero, and act carries a one-hot copy of the route.
module demux_1x8 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic [2:0]       S,
   input  logic             en,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic [WIDTH-1:0] Y4,
   output logic [WIDTH-1:0] Y5,
   output logic [WIDTH-1:0] Y6,
   output logic [WIDTH-1:0] Y7,
   output logic [7:0]       act
);

   logic [WIDTH-1:0] y_q [8];
   logic [WIDTH-1:0] y_d [8];
   logic [7:0]       sel_onehot;
   logic [7:0]       act_q;

   // Full binary decode of S, gated by en; all eight codes are valid routes.
   always_comb begin
      sel_onehot = 8'h00;
      if (en) begin
         sel_onehot[S] = 1'b1;
      end
   end

   // Unselected lanes load zero every cycle, so a previous route never lingers.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         y_d[i] = sel_onehot[i] ? D : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            y_q[i] <= '0;
         end
         act_q <= 8'h00;
      end else begin
         for (int i = 0; i < 8; i++) begin
            y_q[i] <= y_d[i];
         end
         act_q <= sel_onehot;
      end
   end

   // Outputs come straight from the flops; no input reaches an output combinationally.
   assign Y0  = y_q[0];
   assign Y1  = y_q[1];
   assign Y2  = y_q[2];
   assign Y3  = y_q[3];
   assign Y4  = y_q[4];
   assign Y5  = y_q[5];
   assign Y6  = y_q[6];
   assign Y7  = y_q[7];
   assign act = act_q;

endmodule

// File: tb/tb_demux_1x8.sv
// Bench for demux_1x8: a WIDTH=1 and a WIDTH=8 instance share clock, reset, S and en,
// and both are scored against a route model that predicts outputs one cycle ahead.
module tb_demux_1x8;

   localparam int EW = 80;  // {act[7:0], eight 8-bit lanes, eight 1-bit lanes}

   logic       clk;
   logic       rst;
   logic [7:0] d8;
   logic       d1;
   logic [2:0] sel;
   logic       en;

   logic [7:0] y8 [8];
   logic       y1 [8];
   logic [7:0] act8;
   logic [7:0] act1;

   logic [EW-1:0] exp_q [$];
   int n_checks;
   int n_pass;

   demux_1x8 #(.WIDTH(8)) dut_w8 (
      .clk(clk), .rst(rst), .D(d8), .S(sel), .en(en),
      .Y0(y8[0]), .Y1(y8[1]), .Y2(y8[2]), .Y3(y8[3]),
      .Y4(y8[4]), .Y5(y8[5]), .Y6(y8[6]), .Y7(y8[7]),
      .act(act8)
   );

   demux_1x8 #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .D(d1), .S(sel), .en(en),
      .Y0(y1[0]), .Y1(y1[1]), .Y2(y1[2]), .Y3(y1[3]),
      .Y4(y1[4]), .Y5(y1[5]), .Y6(y1[6]), .Y7(y1[7]),
      .act(act1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Route model: the selected lane holds the data, act is 2**S; disabled means all zero.
   function automatic logic [EW-1:0] model(input logic [7:0] d, input logic [2:0] s, input logic e);
      logic [EW-1:0] r;
      int p;
      r = '0;
      if (e) begin
         p = 2 ** int'(s);
         r[79:72] = p[7:0];
         r[8 + int'(s)*8 +: 8] = d;
         r[int'(s)] = d[0];
      end
      return r;
   endfunction

   // Structural invariants: at most one nonzero lane and at most one act bit.
   task automatic check_invariants(input string tag);
      int nz8, nz1, a8, a1;
      nz8 = 0; nz1 = 0; a8 = 0; a1 = 0;
      for (int n = 0; n < 8; n++) begin
         if (y8[n] != 8'h00) nz8++;
         if (y1[n] != 1'b0)  nz1++;
         if (act8[n]) a8++;
         if (act1[n]) a1++;
      end
      check({tag, "_lanes_w8_le1"}, 64'(nz8 <= 1), 64'd1);
      check({tag, "_lanes_w1_le1"}, 64'(nz1 <= 1), 64'd1);
      check({tag, "_act_w8_le1"},   64'(a8 <= 1),  64'd1);
      check({tag, "_act_w1_le1"},   64'(a1 <= 1),  64'd1);
   endtask

   task automatic score(input string tag);
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_underflow"}, 64'd0, 64'd1);
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_act_w8"}, 64'(act8), 64'(e[79:72]));
      check({tag, "_act_w1"}, 64'(act1), 64'(e[79:72]));
      for (int n = 0; n < 8; n++) begin
         check($sformatf("%s_y8_%0d", tag, n), 64'(y8[n]), 64'(e[8 + n*8 +: 8]));
         check($sformatf("%s_y1_%0d", tag, n), 64'(y1[n]), 64'(e[n]));
      end
      check_invariants(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_act_w8"}, 64'(act8), 64'd0);
      check({tag, "_act_w1"}, 64'(act1), 64'd0);
      for (int n = 0; n < 8; n++) begin
         check($sformatf("%s_y8_%0d", tag, n), 64'(y8[n]), 64'd0);
         check($sformatf("%s_y1_%0d", tag, n), 64'(y1[n]), 64'd0);
      end
   endtask

   // driver: apply one sample, clock it in, score outputs just after the edge
   task automatic drive(input string tag, input logic [7:0] d, input logic [2:0] s, input logic e);
      d8  = d;
      d1  = d[0];
      sel = s;
      en  = e;
      exp_q.push_back(model(d, s, e));
      @(posedge clk);
      #1;
      score(tag);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      d8 = 8'hFF; d1 = 1'b1; sel = 3'd4; en = 1'b1;
      #2;
      check_all_zero("reset_initial");
      @(posedge clk);
      #1;
      check_all_zero("reset_held_edge");
      @(negedge clk);
      rst = 1'b0;

      // select sweep
      for (int s = 0; s < 8; s++) begin
         drive($sformatf("sweep_s%0d", s), 8'h01, 3'(s), 1'b1);
      end

      drive("data_zero", 8'h00, 3'd5, 1'b1);
      drive("en_low", 8'h01, 3'd3, 1'b0);
      drive("en_high", 8'h01, 3'd3, 1'b1);
      drive("wide_s7", 8'hA5, 3'd7, 1'b1);
      drive("wide_s0", 8'h3C, 3'd0, 1'b1);

      // asynchronous reset between edges with Y6 loaded
      drive("pre_reset_y6", 8'h01, 3'd6, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      d8 = 8'hFF; d1 = 1'b1; sel = 3'd1; en = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("reset_blocks_edge");
      @(negedge clk);
      rst = 1'b0;
      drive("post_reset_s2", 8'h01, 3'd2, 1'b1);
      check(" post_reset_no_stale_y6", 64'(y8[6]), 64'd0);

      // randomized traffic, en mostly high
      for (int i = 0; i < 300; i++) begin
         drive($sformatf("rand_%0d", i), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0));
      end

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // hard bound on run time
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
